// File: rtl/tdm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package : tdm_pkg
// Shared types for the TDM link (slot counter on the TX side, demux on RX).
// Revision: 1.0
// ---------------------------------------------------------------------------
package tdm_pkg;

   // Receiver framing state: hunting for sync, or locked and collecting slots
   typedef enum logic {
      HUNT    = 1'b0,
      RECEIVE = 1'b1
   } tdm_state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tdm_demux
// Receive end of an N-channel TDM link: one serial bit per slot, slot 0
// flagged by sync, reassembled into an N-bit word with a one-cycle strobe.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tdm_demux
   import tdm_pkg::*;
#(
   parameter  int N  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          din,
   input  logic          din_valid,
   input  logic          sync,
   output logic [N-1:0]  y,
   output logic          y_valid,
   output logic [SW-1:0] slot,
   output logic          locked,
   output logic          sync_err
);

   localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);

   tdm_state_t    state, state_nx;
   logic [SW-1:0] slot_nx;
   logic [N-2:0]  shadow, shadow_nx;
   logic [N-1:0]  y_nx;
   logic          y_valid_nx;
   logic          sync_err_nx;

   // Register all framing state and outputs; reset clears any partial frame
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= HUNT;
         slot     <= '0;
         shadow   <= '0;
         y        <= '0;
         y_valid  <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_nx;
         slot     <= slot_nx;
         shadow   <= shadow_nx;
         y        <= y_nx;
         y_valid  <= y_valid_nx;
         sync_err <= sync_err_nx;
      end
   end

   // Next-state logic: nothing moves unless a bit is accepted, so din is
   // never looked at (and cannot leak X) while din_valid is low
   always_comb begin
      state_nx    = state;
      slot_nx     = slot;
      shadow_nx   = shadow;
      y_nx        = y;
      y_valid_nx  = 1'b0;
      sync_err_nx = 1'b0;

      if (din_valid) begin
         case (state)
            HUNT: begin
               // Non-sync bits are silently dropped while hunting
               if (sync) begin
                  shadow_nx[0] = din;
                  slot_nx      = SLOT_ONE;
                  state_nx     = RECEIVE;
               end
            end

            RECEIVE: begin
               if (slot == '0) begin
                  if (sync) begin
                     shadow_nx[0] = din;
                     slot_nx      = SLOT_ONE;
                  end else begin
                     // Expected a frame start and did not get one
                     sync_err_nx = 1'b1;
                     slot_nx     = '0;
                     state_nx    = HUNT;
                  end
               end else if (sync) begin
                  // Early sync: drop the partial frame, restart on this bit
                  sync_err_nx  = 1'b1;
                  shadow_nx[0] = din;
                  slot_nx      = SLOT_ONE;
               end else if (slot == SLOT_LAST) begin
                  // Last slot goes straight into y, so y is updated whole
                  y_nx       = {din, shadow};
                  y_valid_nx = 1'b1;
                  slot_nx    = '0;
               end else begin
                  for (int i = 0; i < N - 1; i++) begin
                     if (slot == SW'(i)) begin
                        shadow_nx[i] = din;
                     end
                  end
                  slot_nx = slot + SLOT_ONE;
               end
            end

            default: begin
               state_nx = HUNT;
               slot_nx  = '0;
            end
         endcase
      end
   end

   assign locked = (state == RECEIVE);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_tdm_demux
// Scoreboard bench for tdm_demux at N=8 and N=5 against a frame-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tdm_demux;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;

   logic       din_a = 1'b0, valid_a = 1'b0, sync_a = 1'b0;
   logic [7:0] y_a;
   logic       y_valid_a, locked_a, sync_err_a;
   logic [2:0] slot_a;

   logic       din_b = 1'b0, valid_b = 1'b0, sync_b = 1'b0;
   logic [4:0] y_b;
   logic       y_valid_b, locked_b, sync_err_b;
   logic [2:0] slot_b;

   int n_cmp  = 0;
   int n_fail = 0;

   tdm_demux #(.N(8)) dut_a (
      .clk(clk), .n_reset(n_reset), .din(din_a), .din_valid(valid_a),
      .sync(sync_a), .y(y_a), .y_valid(y_valid_a), .slot(slot_a),
      .locked(locked_a), .sync_err(sync_err_a)
   );

   tdm_demux #(.N(5)) dut_b (
      .clk(clk), .n_reset(n_reset), .din(din_b), .din_valid(valid_b),
      .sync(sync_b), .y(y_b), .y_valid(y_valid_b), .slot(slot_b),
      .locked(locked_b), .sync_err(sync_err_b)
   );

   always #5 clk = ~clk;

   // Reference model (frame level): per instance, hunting flag, number of
   // bits gathered in the current frame, and the bits themselves
   bit         hunting [2] = '{1'b1, 1'b1};
   int         cnt     [2] = '{0, 0};
   logic [7:0] acc     [2];
   logic [7:0] qy      [2][$];
   int         qerr    [2] = '{0, 0};
   logic [7:0] pub     [2] = '{8'h00, 8'h00};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_accept(input int id, input bit s, input bit d, input int n);
      if (hunting[id]) begin
         if (s) begin
            acc[id] = '0; acc[id][0] = d; cnt[id] = 1; hunting[id] = 1'b0;
         end
      end else if (s) begin
         if (cnt[id] != 0) qerr[id]++;
         acc[id] = '0; acc[id][0] = d; cnt[id] = 1;
      end else if (cnt[id] == 0) begin
         qerr[id]++;
         hunting[id] = 1'b1;
      end else begin
         acc[id][cnt[id]] = d;
         cnt[id]++;
         if (cnt[id] == n) begin
            qy[id].push_back(acc[id]);
            cnt[id] = 0;
         end
      end
   endtask

   // One clock of stimulus for one instance; the other instance idles.
   // Invalid cycles carry random din/sync, which must have no effect.
   task automatic send(input int id, input bit v, input bit s, input bit d);
      bit ss, dd;
      ss = v ? s : 1'($urandom);
      dd = v ? d : 1'($urandom);
      if (id == 0) begin
         valid_a = v; sync_a = ss; din_a = dd; valid_b = 1'b0;
         if (v) model_accept(0, s, d, 8);
      end else begin
         valid_b = v; sync_b = ss; din_b = dd; valid_a = 1'b0;
         if (v) model_accept(1, s, d, 5);
      end
      @(posedge clk);
      @(negedge clk);
      if (id == 0) begin
         chk("slot_a",   32'(slot_a),   hunting[0] ? 32'd0 : 32'(cnt[0]));
         chk("locked_a", 32'(locked_a), 32'(!hunting[0]));
      end else begin
         chk("slot_b",   32'(slot_b),   hunting[1] ? 32'd0 : 32'(cnt[1]));
         chk("locked_b", 32'(locked_b), 32'(!hunting[1]));
      end
   endtask

   // Complete frame; stall_mask bit i inserts 3 idle cycles after slot i
   task automatic frame(input int id, input int n, input logic [7:0] w, input logic [7:0] stall_mask);
      for (int i = 0; i < n; i++) begin
         send(id, 1'b1, i == 0, w[i]);
         if (stall_mask[i]) begin
            for (int k = 0; k < 3; k++) send(id, 1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic rand_frames(input int id, input int n, input int nframes);
      logic [7:0] w;
      bit s;
      for (int f = 0; f < nframes; f++) begin
         w = 8'($urandom);
         for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) send(id, 1'b0, 1'b0, 1'b0);
            s = (i == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
            send(id, 1'b1, s, w[i]);
         end
      end
   endtask

   // Monitor: pops the expected word on every strobe, otherwise y must hold
   always @(negedge clk) begin
      logic [7:0] e;
      if (n_reset) begin
         if (y_valid_a) begin
            if (qy[0].size() == 0) chk("y_valid_a_unexpected", 32'(y_valid_a), 32'd0);
            else begin
               e = qy[0].pop_front();
               chk("y_a", 32'(y_a), 32'(e));
               pub[0] = e;
            end
         end else chk("y_a_hold", 32'(y_a), 32'(pub[0]));
         if (sync_err_a) begin
            chk("sync_err_a_expected", 32'(qerr[0] > 0), 32'd1);
            if (qerr[0] > 0) qerr[0]--;
         end
         if (y_valid_b) begin
            if (qy[1].size() == 0) chk("y_valid_b_unexpected", 32'(y_valid_b), 32'd0);
            else begin
               e = qy[1].pop_front();
               chk("y_b", 32'(y_b), 32'(e[4:0]));
               pub[1] = e;
            end
         end else chk("y_b_hold", 32'(y_b), 32'(pub[1][4:0]));
         if (sync_err_b) begin
            chk("sync_err_b_expected", 32'(qerr[1] > 0), 32'd1);
            if (qerr[1] > 0) qerr[1]--;
         end
      end
   end

   task automatic drain_check(input string tag);
      send(0, 1'b0, 1'b0, 1'b0);
      send(0, 1'b0, 1'b0, 1'b0);
      chk({tag, "_pending_y_a"},   32'(qy[0].size()), 32'd0);
      chk({tag, "_pending_err_a"}, 32'(qerr[0]),      32'd0);
      chk({tag, "_pending_y_b"},   32'(qy[1].size()), 32'd0);
      chk({tag, "_pending_err_b"}, 32'(qerr[1]),      32'd0);
   endtask

   initial begin
      #2;
      chk("rst_y_a",      32'(y_a),        32'd0);
      chk("rst_slot_a",   32'(slot_a),     32'd0);
      chk("rst_locked_a", 32'(locked_a),   32'd0);
      chk("rst_yv_a",     32'(y_valid_a),  32'd0);
      chk("rst_err_a",    32'(sync_err_a), 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);

      // Plain frame, then the same frame with stalls after slots 2 and 5
      frame(0, 8, 8'hAC, 8'h00);
      frame(0, 8, 8'hAC, 8'b0010_0100);
      drain_check("basic");

      // Early sync after 4 bits, then a clean frame
      for (int i = 0; i < 4; i++) send(0, 1'b1, i == 0, 1'b1);
      frame(0, 8, 8'h5A, 8'h00);
      drain_check("early");

      // Missing sync at the frame boundary, then bits ignored while hunting
      frame(0, 8, 8'hAC, 8'h00);
      for (int i = 0; i < 5; i++) send(0, 1'b1, 1'b0, 1'($urandom));
      frame(0, 8, 8'h3C, 8'h00);
      drain_check("nosync");

      // Asynchronous reset in the middle of a frame
      for (int i = 0; i < 4; i++) send(0, 1'b1, i == 0, 1'b1);
      #2;
      n_reset = 1'b0;
      hunting = '{1'b1, 1'b1}; cnt = '{0, 0}; pub = '{8'h00, 8'h00};
      #1;
      chk("arst_y_a",      32'(y_a),      32'd0);
      chk("arst_slot_a",   32'(slot_a),   32'd0);
      chk("arst_locked_a", 32'(locked_a), 32'd0);
      @(negedge clk);
      #1 n_reset = 1'b1;
      @(negedge clk);
      frame(0, 8, 8'hFF, 8'h00);
      drain_check("arst");

      rand_frames(0, 8, 40);
      drain_check("rand_a");

      // N=5: two back-to-back frames, then randomized traffic
      frame(1, 5, 8'b0001_0011, 8'h00);
      frame(1, 5, 8'b0000_1100, 8'h00);
      drain_check("n5");
      rand_frames(1, 5, 50);
      drain_check("rand_b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
